// File: rtl/ex_writeback.sv
// ex_writeback: execute/writeback stage after the 16-bit ALU (flags, writeback, PC redirect, halt FSM).
// Optional retired-instruction counter enabled by defining RETIRE_COUNTER_EN.
`default_nettype none

module ex_writeback #(
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               stall,
  input  logic [1:0]         op1,
  input  logic [2:0]         op2,
  input  logic [3:0]         opcode,
  input  logic [RADDR_W-1:0] rd,
  input  logic [15:0]        alu_out,
  input  logic               alu_s,
  input  logic               alu_z,
  input  logic               alu_c,
  input  logic               alu_v,
  input  logic               alu_hlt,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [15:0]        wb_data,
  output logic               pc_we,
  output logic [15:0]        pc_data,
  output logic               flag_s,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_v,
  output logic               halted,
  input  logic               resume,
  output logic [15:0]        retired
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic accept;
  logic dec_wb;
  logic dec_flags;
  logic dec_pc;
  logic dec_halt;

  assign in_ready = (state == RUN) && !stall;
  assign accept   = in_valid && in_ready;
  assign halted   = (state == HALTED);

  // Halt takes priority over every other action of the instruction.
  always_comb begin
    dec_wb    = 1'b0;
    dec_flags = 1'b0;
    dec_pc    = 1'b0;
    dec_halt  = 1'b0;
    if (alu_hlt || (op1 == 2'b11 && opcode == 4'd15)) begin
      dec_halt = 1'b1;
    end else if (op1 == 2'b11) begin
      case (opcode)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6,
        4'd8, 4'd9, 4'd10, 4'd11: begin
          dec_wb    = 1'b1;
          dec_flags = 1'b1;
        end
        4'd5:    dec_flags = 1'b1;
        default: ;
      endcase
    end else if (op1 == 2'b10) begin
      case (op2)
        3'b000: dec_wb = 1'b1;
        3'b001: begin
          dec_wb    = 1'b1;
          dec_flags = 1'b1;
        end
        3'b010:                 dec_flags = 1'b1;
        3'b100, 3'b110, 3'b111: dec_pc    = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // A resume in HALTED wins; in_ready is low there so nothing is accepted that cycle.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (accept && dec_halt) state_next = HALTED;
      HALTED:  if (resume)             state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= 16'h0000;
      pc_we   <= 1'b0;
      pc_data <= 16'h0000;
      flag_s  <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
    end else begin
      wb_we <= accept && dec_wb;
      pc_we <= accept && dec_pc;
      if (accept && dec_wb) begin
        wb_addr <= rd;
        wb_data <= alu_out;
      end
      if (accept && dec_pc) begin
        pc_data <= alu_out;
      end
      if (accept && dec_flags) begin
        flag_s <= alu_s;
        flag_z <= alu_z;
        flag_c <= alu_c;
        flag_v <= alu_v;
      end
    end
  end

`ifdef RETIRE_COUNTER_EN
  logic [15:0] retire_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= 16'h0000;
    end else if (accept && retire_cnt != 16'hFFFF) begin
      retire_cnt <= retire_cnt + 16'd1;
    end
  end

  assign retired = retire_cnt;
`else
  assign retired = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_writeback.sv
// Self-checking bench for ex_writeback: reference model feeds a queue of expected outputs.
`default_nettype none

module tb_ex_writeback;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        stall;
  logic [1:0]  op1;
  logic [2:0]  op2;
  logic [3:0]  opcode;
  logic [2:0]  rd;
  logic [15:0] alu_out;
  logic        alu_s, alu_z, alu_c, alu_v, alu_hlt;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        pc_we;
  logic [15:0] pc_data;
  logic        flag_s, flag_z, flag_c, flag_v;
  logic        halted;
  logic        resume;
  logic [15:0] retired;

  ex_writeback #(.RADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .stall(stall),
    .op1(op1), .op2(op2), .opcode(opcode), .rd(rd), .alu_out(alu_out),
    .alu_s(alu_s), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .alu_hlt(alu_hlt),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .pc_we(pc_we), .pc_data(pc_data),
    .flag_s(flag_s), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .halted(halted), .resume(resume), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_ready;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        pc_we;
    logic [15:0] pc_data;
    logic [3:0]  flags;
    logic        halted;
    logic [15:0] retired;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic        m_halted;
  logic [3:0]  m_flags;
  logic [2:0]  m_wb_addr;
  logic [15:0] m_wb_data;
  logic [15:0] m_pc_data;
  logic [15:0] m_ret;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_halted  = 1'b0;
    m_flags   = 4'h0;
    m_wb_addr = 3'd0;
    m_wb_data = 16'h0000;
    m_pc_data = 16'h0000;
    m_ret     = 16'h0000;
  endtask

  task automatic drive(input logic v, input logic [1:0] o1, input logic [2:0] o2,
                       input logic [3:0] opc, input logic [2:0] r, input logic [15:0] d,
                       input logic [3:0] szcv, input logic h);
    in_valid = v; op1 = o1; op2 = o2; opcode = opc; rd = r; alu_out = d;
    {alu_s, alu_z, alu_c, alu_v} = szcv; alu_hlt = h;
  endtask

  // Predict the outputs after the next edge, push them, clock, then pop and compare.
  task automatic cycle();
    exp_t e, g;
    logic acc, wb, fl, pc, hl;
    acc = in_valid && !m_halted && !stall;
    wb = 1'b0; fl = 1'b0; pc = 1'b0; hl = 1'b0;
    if (alu_hlt || (op1 == 2'b11 && opcode == 4'hF)) hl = 1'b1;
    else if (op1 == 2'b11) begin
      if (opcode == 4'd5) fl = 1'b1;
      else if (opcode <= 4'd4 || opcode == 4'd6 || (opcode >= 4'd8 && opcode <= 4'd11)) begin
        wb = 1'b1; fl = 1'b1;
      end
    end else if (op1 == 2'b10) begin
      if (op2 == 3'b000) wb = 1'b1;
      if (op2 == 3'b001) begin wb = 1'b1; fl = 1'b1; end
      if (op2 == 3'b010) fl = 1'b1;
      if (op2 == 3'b100 || op2 == 3'b110 || op2 == 3'b111) pc = 1'b1;
    end
    e.wb_we = acc && wb;
    e.pc_we = acc && pc;
    if (acc && wb) begin m_wb_addr = rd; m_wb_data = alu_out; end
    if (acc && pc) m_pc_data = alu_out;
    if (acc && fl) m_flags = {alu_s, alu_z, alu_c, alu_v};
`ifdef RETIRE_COUNTER_EN
    if (acc && m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
`endif
    if (m_halted) begin
      if (resume) m_halted = 1'b0;
    end else if (acc && hl) m_halted = 1'b1;
    e.wb_addr  = m_wb_addr;
    e.wb_data  = m_wb_data;
    e.pc_data  = m_pc_data;
    e.flags    = m_flags;
    e.halted   = m_halted;
    e.retired  = m_ret;
    e.in_ready = !m_halted && !stall;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("in_ready", {31'd0, in_ready}, {31'd0, g.in_ready});
    check("wb_we",    {31'd0, wb_we},    {31'd0, g.wb_we});
    check("wb_addr",  {29'd0, wb_addr},  {29'd0, g.wb_addr});
    check("wb_data",  {16'd0, wb_data},  {16'd0, g.wb_data});
    check("pc_we",    {31'd0, pc_we},    {31'd0, g.pc_we});
    check("pc_data",  {16'd0, pc_data},  {16'd0, g.pc_data});
    check("flags",    {28'd0, flag_s, flag_z, flag_c, flag_v}, {28'd0, g.flags});
    check("halted",   {31'd0, halted},   {31'd0, g.halted});
    check("retired",  {16'd0, retired},  {16'd0, g.retired});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {31'd0, in_ready}, {31'd0, !stall});
    check({tag, "_wb"}, {12'd0, wb_we, wb_addr, wb_data}, 32'd0);
    check({tag, "_pc"}, {15'd0, pc_we, pc_data}, 32'd0);
    check({tag, "_flags"}, {28'd0, flag_s, flag_z, flag_c, flag_v}, 32'd0);
    check({tag, "_halt"}, {31'd0, halted}, 32'd0);
    check({tag, "_ret"}, {16'd0, retired}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; resume = 1'b0;
    drive(1'b0, 2'b00, 3'd0, 4'd0, 3'd0, 16'h0, 4'h0, 1'b0);
    model_reset();
    #12;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU write of rd=3, then idle
    drive(1'b1, 2'b11, 3'd0, 4'd0, 3'd3, 16'h1234, 4'b0000, 1'b0); cycle();
    drive(1'b0, 2'b11, 3'd0, 4'd0, 3'd0, 16'h0, 4'b0000, 1'b0); cycle();

    // Compare sets Z only; then unconditional branch redirect
    drive(1'b1, 2'b11, 3'd0, 4'd5, 3'd1, 16'hBEEF, 4'b0100, 1'b0); cycle();
    drive(1'b1, 2'b10, 3'b111, 4'd0, 3'd2, 16'h0040, 4'b1011, 1'b0); cycle();
    drive(1'b1, 2'b10, 3'b001, 4'd0, 3'd0, 16'h5555, 4'b1010, 1'b0); cycle();
    drive(1'b1, 2'b11, 3'd0, 4'd7, 3'd4, 16'h7777, 4'b1111, 1'b0); cycle();
    drive(1'b1, 2'b01, 3'd0, 4'd0, 3'd5, 16'h1111, 4'b1111, 1'b0); cycle();

    // Halt, ignored input while halted, resume with in_valid, then accept
    drive(1'b1, 2'b11, 3'd0, 4'hF, 3'd6, 16'hDEAD, 4'b1111, 1'b0); cycle();
    drive(1'b1, 2'b11, 3'd0, 4'd0, 3'd6, 16'hAAAA, 4'b1111, 1'b0);
    repeat (5) cycle();
    resume = 1'b1; cycle();
    resume = 1'b0; cycle();

    // resume in RUN is ignored; alu_hlt on a writeback op halts without writing
    resume = 1'b1;
    drive(1'b1, 2'b10, 3'b000, 4'd0, 3'd7, 16'h0F0F, 4'b0000, 1'b0); cycle();
    resume = 1'b0;
    drive(1'b1, 2'b11, 3'd0, 4'd1, 3'd2, 16'hCAFE, 4'b0001, 1'b1); cycle();
    drive(1'b0, 2'b11, 3'd0, 4'd1, 3'd2, 16'hCAFE, 4'b0001, 1'b0); cycle();
    resume = 1'b1; cycle();
    resume = 1'b0;

    // Stall holds for 3 cycles, then a single accept
    stall = 1'b1;
    drive(1'b1, 2'b11, 3'd0, 4'd2, 3'd1, 16'h2222, 4'b0110, 1'b0);
    repeat (3) cycle();
    stall = 1'b0; cycle();
    drive(1'b0, 2'b11, 3'd0, 4'd2, 3'd1, 16'h2222, 4'b0110, 1'b0); cycle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      stall  = ($urandom_range(0, 5) == 0);
      resume = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 4) != 0, 2'($urandom), 3'($urandom), 4'($urandom),
            3'($urandom), 16'($urandom), 4'($urandom), $urandom_range(0, 15) == 0);
      cycle();
    end
    stall = 1'b0; resume = 1'b0;

`ifdef RETIRE_COUNTER_EN
    // Drive the counter to saturation with no-action accepts
    resume = 1'b1;
    drive(1'b0, 2'b00, 3'd0, 4'd0, 3'd0, 16'h0, 4'h0, 1'b0); cycle();
    resume = 1'b0;
    drive(1'b1, 2'b00, 3'd0, 4'd0, 3'd0, 16'h0, 4'h0, 1'b0);
    repeat (65540) @(posedge clk);
    #1;
    m_ret = 16'hFFFF;
    cycle();
    cycle();
`endif

    // Set all flags, halt, then drop reset between edges
    resume = 1'b1;
    drive(1'b0, 2'b00, 3'd0, 4'd0, 3'd0, 16'h0, 4'h0, 1'b0); cycle();
    resume = 1'b0;
    drive(1'b1, 2'b11, 3'd0, 4'd0, 3'd5, 16'h9999, 4'b1111, 1'b0); cycle();
    drive(1'b1, 2'b11, 3'd0, 4'hF, 3'd5, 16'h9999, 4'b1111, 1'b0); cycle();
    drive(1'b0, 2'b00, 3'd0, 4'd0, 3'd0, 16'h0, 4'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 2'b10, 3'b000, 4'd0, 3'd0, 16'h0ABC, 4'h0, 1'b0); cycle();
    drive(1'b0, 2'b00, 3'd0, 4'd0, 3'd0, 16'h0, 4'h0, 1'b0); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_writeback.md
# ex_writeback

Execute/writeback stage directly downstream of the 16-bit ALU. It registers the ALU result and the S/Z/C/V/HLT outputs, and drives register-file writeback and PC redirect. It holds the architectural flag register that feeds the ALU's S_in/Z_in/C_in/V_in, and runs the halt state machine. It accepts one instruction per cycle under a valid/ready handshake.

## Interface
Parameters:
- RADDR_W, 3, register-file address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU output is a valid instruction.
- in_ready  out  1  stage accepts this cycle; equals (state==RUN) && !stall.
- stall  in  1  hazard hold from control; forces in_ready=0.
- op1  in  2  instruction class.
- op2  in  3  sub-op for op1=2'b10.
- opcode  in  4  sub-op for op1=2'b11.
- rd  in  RADDR_W  destination register (Rd, or Rb for op1=10).
- alu_out  in  16  ALU result or branch target.
- alu_s, alu_z, alu_c, alu_v  in  1 each  ALU flag outputs.
- alu_hlt  in  1  ALU halt indication.
- wb_we  out  1  register-file write strobe.
- wb_addr  out  RADDR_W  write address.
- wb_data  out  16  write data.
- pc_we  out  1  PC load strobe.
- pc_data  out  16  PC load value.
- flag_s, flag_z, flag_c, flag_v  out  1 each  flag register; wired to the ALU flag inputs.
- halted  out  1  stage in HALTED state.
- resume  in  1  leave HALTED.
- retired  out  16  retired-instruction count (see Configuration).

## Operation
- An accept occurs when in_valid && in_ready at a rising edge. All actions below happen only on an accept.
- Instruction decode:
  - op1=11, opcode in {0,1,2,3,4,6,8,9,10,11}: write rd with alu_out; update flags.
  - op1=11, opcode 5 (compare): update flags only.
  - op1=11, opcode 15, or alu_hlt=1: halt. No writeback. Flags are left unchanged.
  - op1=11, opcodes 7, 12, 13, 14: no action.
  - op1=10, op2=000 or 001: write rd. For 001, also update flags.
  - op1=10, op2=010: update flags only.
  - op1=10, op2=100, 110 or 111: pc_we with pc_data=alu_out. The ALU has already resolved the condition, so the redirect is unconditional here.
  - op1=10, op2=101, op1=10 with op2=011, and op1=00/01: no action. Memory access is handled by a separate stage.
- Flag update loads all four of alu_s, alu_z, alu_c and alu_v together. Partial updates do not exist.
- State machine:
  - RUN: accepts instructions. An accept with a halt condition moves to HALTED.
  - HALTED: in_ready=0; halted=1. resume=1 at an edge returns to RUN.
  - The halting instruction itself counts as retired.
- Boundary conditions:
  - in_valid while stall=1: nothing accepted; all outputs hold except the strobes, which deassert.
  - resume while in RUN: ignored.
  - resume and in_valid together in HALTED: return to RUN; that cycle's in_valid is not accepted.
  - rst_n low at any time, including mid-halt or with a strobe high: immediate return to reset state.
  - A writeback to any rd value, including 0, is performed. The register file decides r0 semantics.

## Timing
- Reset values:
  - state=RUN, so in_ready=!stall.
  - wb_we=0, wb_addr=0, wb_data=0.
  - pc_we=0, pc_data=0.
  - flag_s, flag_z, flag_c, flag_v = 0.
  - halted=0, retired=0.
- Latency is one cycle. An accept at edge k makes wb_*, pc_*, the new flags and halted valid from edge k until edge k+1.
- wb_we and pc_we are single-cycle pulses. They are low in any cycle following a non-accepting edge.
- wb_addr/wb_data and pc_data hold their last values when their strobe is low.
- Flags are visible to the ALU the cycle after the updating instruction is accepted. Back-to-back flag use is therefore correct without a bypass.
- Throughput is one instruction per cycle while in RUN and not stalled.

## Configuration
- RETIRE_COUNTER_EN defined: retired increments by 1 on every accept. It saturates at 16'hFFFF and resets to 0.
- RETIRE_COUNTER_EN undefined: retired is tied to 16'h0000 and no counter flop exists.

## Test plan
- Reset, then accept op1=11 opcode 0, rd=3, alu_out=16'h1234, S/Z/C/V=0/0/0/0 -> next cycle: wb_we=1, wb_addr=3, wb_data=16'h1234, flags 0000; following cycle wb_we=0.
- Accept opcode 5 with alu_z=1, then op1=10 op2=111 with alu_out=16'h0040 -> first gives flag_z=1 and wb_we=0; second gives pc_we=1, pc_data=16'h0040, flag_z still 1.
- Accept opcode 15 -> halted=1 and in_ready=0 from the next cycle; in_valid ignored 5 cycles; resume with in_valid=1 -> RUN with no accept that cycle; next cycle accepts.
- Hold stall=1 with in_valid=1 for 3 cycles -> no strobes, flags unchanged, retired unchanged; release -> single accept.
- Drop rst_n mid-HALTED with flags=1111 -> all outputs at reset values immediately, without waiting for a clock edge.
- With RETIRE_COUNTER_EN defined, accept 3 instructions -> retired=3; preload to 16'hFFFF and accept one -> stays 16'hFFFF; undefined -> always 0.
